irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/sopc_pkg.sv | 35 +++
 rtl/irq_ctrl_if.sv | 22 ++
 rtl/irq_edge_det.sv | 19 +
 rtl/irq_ctrl.sv | 123 ++++++++++++
 tb/tb_irq_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/sopc_pkg.sv
// rtl/sopc_pkg.sv - shared register offsets, IRQ bit offset and helpers for the SoPC peripherals
package sopc_pkg;

   localparam int NIRQ_MAX    = 32;
   localparam int IRQ_BIT_OFS = 3;

   localparam logic [3:0] OFS_PEND   = 4'h0;
   localparam logic [3:0] OFS_ENABLE = 4'h4;
   localparam logic [3:0] OFS_MODE   = 4'h8;
   localparam logic [3:0] OFS_RAW    = 4'hC;

   typedef enum logic [1:0] {
      REG_PEND   = 2'd0,
      REG_ENABLE = 2'd1,
      REG_MODE   = 2'd2,
      REG_RAW    = 2'd3
   } reg_sel_e;

   // Byte offset to register select; the low two address bits do not matter.
   function automatic reg_sel_e reg_decode(input logic [3:0] addr);
      reg_sel_e sel;
      case (addr & 4'hC)
         OFS_PEND:   sel = REG_PEND;
         OFS_ENABLE: sel = REG_ENABLE;
         OFS_MODE:   sel = REG_MODE;
         default:    sel = REG_RAW;
      endcase
      return sel;
   endfunction

   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
   endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - register bus between the processor and the interrupt controller
interface irq_ctrl_if;

   logic        SEL;
   logic        VALID;
   logic [3:0]  ADDR;
   logic [3:0]  WSTRB;
   logic [31:0] WDATA;
   logic [31:0] RDATA;
   logic        READY;

   modport master (
      output SEL, VALID, ADDR, WSTRB, WDATA,
      input  RDATA, READY
   );

   modport slave (
      input  SEL, VALID, ADDR, WSTRB, WDATA,
      output RDATA, READY
   );

endinterface

// File: rtl/irq_edge_det.sv
// rtl/irq_edge_det.sv - single-line rising-edge detector against a registered copy
module irq_edge_det (
   input  logic CLK,
   input  logic RSTn,
   input  logic i_d,
   output logic o_rise
);

   logic r_q;

   // Resetting the copy to 0 makes a line already high at reset release look like an edge.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) r_q <= 1'b0;
      else       r_q <= i_d;
   end

   assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - interrupt controller: pending/enable/mode registers and CPU interrupt vector
module irq_ctrl
   import sopc_pkg::*;
#(
   parameter int              NIRQ   = 8,
   parameter logic [NIRQ-1:0] RST_EN = {NIRQ{1'b0}}
) (
   input  logic                CLK,
   input  logic                RSTn,
   irq_ctrl_if.slave           bus,
   input  logic [NIRQ-1:0]     IRQ_IN,
   output logic [NIRQ_MAX-1:0] CPU_IRQ,
   input  logic [NIRQ_MAX-1:0] CPU_EOI
);

   logic [NIRQ-1:0] r_pend;
   logic [NIRQ-1:0] r_enable;
   logic [NIRQ-1:0] r_mode;
   logic [NIRQ-1:0] r_eoi_q;
   logic            r_ready;
   logic [31:0]     r_rdata;
   logic [NIRQ_MAX-1:0] r_cpu_irq;

   logic            w_accept;
   logic            w_wr;
   reg_sel_e        w_sel;
   logic [31:0]     w_wmask;
   logic [NIRQ-1:0] w_keep;
   logic [NIRQ-1:0] w_wbits;
   logic [NIRQ-1:0] w_enable_nxt;
   logic [NIRQ-1:0] w_mode_nxt;
   logic [NIRQ-1:0] w_w1c;
   logic [NIRQ-1:0] w_eoi;
   logic [NIRQ-1:0] w_eoi_rise;
   logic [NIRQ-1:0] w_rise;
   logic [NIRQ-1:0] w_pend_nxt;
   logic [NIRQ-1:0] w_line;
   logic [NIRQ+IRQ_BIT_OFS-1:0] w_cpu_wide;
   logic [31:0]     w_rdata_nxt;

   // The READY cycle blocks acceptance, so back-to-back requests see one pulse each.
   assign w_accept = bus.SEL & bus.VALID & ~r_ready;
   assign w_wr     = w_accept & (|bus.WSTRB);
   assign w_sel    = reg_decode(bus.ADDR);
   assign w_wmask  = strb_mask(bus.WSTRB);
   assign w_keep   = NIRQ'(w_wmask);
   assign w_wbits  = NIRQ'(bus.WDATA & w_wmask);

   assign w_enable_nxt = (w_wr && w_sel == REG_ENABLE) ? ((r_enable & ~w_keep) | w_wbits) : r_enable;
   assign w_mode_nxt   = (w_wr && w_sel == REG_MODE)   ? ((r_mode   & ~w_keep) | w_wbits) : r_mode;
   assign w_w1c        = (w_wr && w_sel == REG_PEND)   ? w_wbits : '0;

   assign w_eoi      = NIRQ'(CPU_EOI >> IRQ_BIT_OFS);
   assign w_eoi_rise = w_eoi & ~r_eoi_q;

   genvar g;
   generate
      for (g = 0; g < NIRQ; g++) begin : g_edge
         irq_edge_det u_edge (
            .CLK    (CLK),
            .RSTn   (RSTn),
            .i_d    (IRQ_IN[g]),
            .o_rise (w_rise[g])
         );
      end
   endgenerate

   always_comb begin
      w_pend_nxt = r_pend;
      for (int i = 0; i < NIRQ; i++) begin
         if (!r_mode[i] && w_mode_nxt[i]) begin
            // Entering edge mode starts from a clean slate; the shared edge copy
            // has been tracking the line all along, so no stale edge appears.
            w_pend_nxt[i] = 1'b0;
         end else if (r_mode[i]) begin
            if (w_w1c[i] || w_eoi_rise[i]) w_pend_nxt[i] = 1'b0;
            if (w_rise[i])                 w_pend_nxt[i] = 1'b1;
         end else begin
            w_pend_nxt[i] = IRQ_IN[i];
         end
      end
   end

   assign w_line     = r_pend & r_enable & ~w_eoi;
   assign w_cpu_wide = {w_line, {IRQ_BIT_OFS{1'b0}}};

   always_comb begin
      w_rdata_nxt = '0;
      if (w_accept && !w_wr) begin
         case (w_sel)
            REG_PEND:   w_rdata_nxt = 32'(r_pend);
            REG_ENABLE: w_rdata_nxt = 32'(r_enable);
            REG_MODE:   w_rdata_nxt = 32'(r_mode);
            default:    w_rdata_nxt = 32'(IRQ_IN);
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_pend    <= '0;
         r_enable  <= RST_EN;
         r_mode    <= '0;
         r_eoi_q   <= '0;
         r_ready   <= 1'b0;
         r_rdata   <= '0;
         r_cpu_irq <= '0;
      end else begin
         r_pend    <= w_pend_nxt;
         r_enable  <= w_enable_nxt;
         r_mode    <= w_mode_nxt;
         r_eoi_q   <= w_eoi;
         r_ready   <= w_accept;
         r_rdata   <= w_rdata_nxt;
         r_cpu_irq <= NIRQ_MAX'(w_cpu_wide);
      end
   end

   assign bus.READY = r_ready;
   assign bus.RDATA = r_rdata;
   assign CPU_IRQ   = r_cpu_irq;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed self-checking bench for irq_ctrl
module tb_irq_ctrl;

   localparam int NIRQ = 16;

   logic            CLK;
   logic            RSTn;
   logic [NIRQ-1:0] IRQ_IN;
   logic [31:0]     CPU_IRQ;
   logic [31:0]     CPU_EOI;

   int n_pass;
   int n_total;
   logic [31:0] rd;
   logic [31:0] irq_seen;
   int ready_cnt;

   irq_ctrl_if bus_if ();

   irq_ctrl #(.NIRQ(NIRQ)) dut (
      .CLK     (CLK),
      .RSTn    (RSTn),
      .bus     (bus_if),
      .IRQ_IN  (IRQ_IN),
      .CPU_IRQ (CPU_IRQ),
      .CPU_EOI (CPU_EOI)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 after the READY cycle.
   task automatic bus_xfer(input string tag, input logic [3:0] a, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] data);
      bus_if.SEL   = 1'b1;
      bus_if.VALID = 1'b1;
      bus_if.ADDR  = a;
      bus_if.WSTRB = s;
      bus_if.WDATA = d;
      tick();
      bus_if.SEL   = 1'b0;
      bus_if.VALID = 1'b0;
      bus_if.WSTRB = 4'h0;
      @(negedge CLK);
      data     = bus_if.RDATA;
      irq_seen = CPU_IRQ;
      chk({tag, "_ready"}, 32'(bus_if.READY), 32'd1);
      tick();
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      RSTn = 1'b0;
      IRQ_IN = '0;
      CPU_EOI = '0;
      bus_if.SEL = 1'b0;
      bus_if.VALID = 1'b0;
      bus_if.ADDR = 4'h0;
      bus_if.WSTRB = 4'h0;
      bus_if.WDATA = '0;
      repeat (3) tick();
      @(negedge CLK);
      chk("rst_cpu_irq", CPU_IRQ, 32'h0);
      chk("rst_ready", 32'(bus_if.READY), 32'h0);
      chk("rst_rdata", bus_if.RDATA, 32'h0);
      tick();
      RSTn = 1'b1;
      tick();
      bus_xfer("rd_pend0", 4'h0, 4'h0, 0, rd);   chk("rst_pend", rd, 32'h0);
      bus_xfer("rd_en0",   4'h4, 4'h0, 0, rd);   chk("rst_enable", rd, 32'h0);
      bus_xfer("rd_mode0", 4'h8, 4'h0, 0, rd);   chk("rst_mode", rd, 32'h0);

      // Edge mode on line 0: pulse -> PEND next cycle, CPU_IRQ the cycle after
      bus_xfer("wr_mode", 4'h8, 4'hF, 32'h1, rd);
      chk("wr_rdata_zero", rd, 32'h0);
      bus_xfer("wr_en", 4'h4, 4'hF, 32'h1, rd);
      IRQ_IN[0] = 1'b1;
      tick();
      IRQ_IN[0] = 1'b0;
      @(negedge CLK);
      chk("edge_pend", 32'(dut.r_pend), 32'h1);
      chk("edge_irq_lat", CPU_IRQ, 32'h0);
      tick();
      @(negedge CLK);
      chk("edge_irq", CPU_IRQ, 32'h8);
      tick();

      // EOI rising edge clears; no re-assertion while held
      CPU_EOI[3] = 1'b1;
      tick();
      @(negedge CLK);
      chk("eoi_irq", CPU_IRQ, 32'h0);
      chk("eoi_pend", 32'(dut.r_pend), 32'h0);
      repeat (3) tick();
      chk("eoi_held", CPU_IRQ, 32'h0);
      CPU_EOI[3] = 1'b0;
      repeat (2) tick();
      chk("eoi_release", CPU_IRQ, 32'h0);

      // W1C colliding with a new edge: set wins
      IRQ_IN[0] = 1'b1;
      tick();
      IRQ_IN[0] = 1'b0;
      tick();
      bus_if.SEL = 1'b1; bus_if.VALID = 1'b1; bus_if.ADDR = 4'h0;
      bus_if.WSTRB = 4'h1; bus_if.WDATA = 32'h1;
      IRQ_IN[0] = 1'b1;
      tick();
      bus_if.SEL = 1'b0; bus_if.VALID = 1'b0; bus_if.WSTRB = 4'h0;
      @(negedge CLK);
      chk("w1c_set_ready", 32'(bus_if.READY), 32'h1);
      chk("w1c_set_wins", 32'(dut.r_pend), 32'h1);
      tick();
      bus_xfer("w1c", 4'h0, 4'h1, 32'h1, rd);
      bus_xfer("rd_pend_w1c", 4'h0, 4'h0, 0, rd);
      chk("w1c_clears", rd, 32'h0);
      IRQ_IN[0] = 1'b0;

      // Level -> edge mode switch clears pending with no spurious edge
      IRQ_IN[1] = 1'b1;
      repeat (2) tick();
      bus_xfer("rd_pend_lvl1", 4'h0, 4'h0, 0, rd);
      chk("lvl1_pend", rd, 32'h2);
      bus_xfer("wr_mode3", 4'h8, 4'hF, 32'h3, rd);
      tick();
      bus_xfer("rd_pend_sw", 4'h0, 4'h0, 0, rd);
      chk("mode_sw_clear", rd, 32'h0);
      IRQ_IN[1] = 1'b0;
      bus_xfer("wr_mode1", 4'h8, 4'hF, 32'h1, rd);

      // Level mode line 2, pending recorded while disabled
      bus_xfer("wr_en0", 4'h4, 4'hF, 32'h0, rd);
      IRQ_IN[2] = 1'b1;
      tick();
      bus_xfer("rd_pend_lvl2", 4'h0, 4'h0, 0, rd);
      chk("lvl2_pend", rd, 32'h4);
      chk("lvl2_irq_off", CPU_IRQ, 32'h0);
      bus_xfer("wr_en4", 4'h4, 4'hF, 32'h4, rd);
      chk("lvl2_irq_lat", irq_seen, 32'h0);
      @(negedge CLK);
      chk("lvl2_irq_on", CPU_IRQ, 32'h20);
      tick();
      bus_xfer("w1c_lvl", 4'h0, 4'hF, 32'h4, rd);
      bus_xfer("rd_pend_lvl_w1c", 4'h0, 4'h0, 0, rd);
      chk("lvl_w1c_noeff", rd, 32'h4);
      IRQ_IN[2] = 1'b0;

      // Byte strobes, unimplemented bits, RAW read-only
      bus_xfer("wr_en_clr", 4'h4, 4'hF, 32'h0, rd);
      bus_xfer("wr_en_b1", 4'h4, 4'h2, 32'hFFFF, rd);
      @(negedge CLK);
      chk("ready_pulse_w", 32'(bus_if.READY), 32'h0);
      chk("idle_rdata", bus_if.RDATA, 32'h0);
      tick();
      bus_xfer("rd_en_b1", 4'h4, 4'h0, 0, rd);
      chk("byte_strobe", rd, 32'hFF00);
      bus_xfer("wr_mode_all", 4'h8, 4'hF, 32'hFFFF_FFFF, rd);
      bus_xfer("rd_mode_all", 4'h8, 4'h0, 0, rd);
      chk("upper_bits_zero", rd, 32'h0000_FFFF);
      bus_xfer("wr_mode_clr", 4'h8, 4'hF, 32'h0, rd);
      IRQ_IN = 16'h0005;
      bus_xfer("wr_raw", 4'hC, 4'hF, 32'h1234, rd);
      bus_xfer("rd_raw", 4'hD, 4'h0, 0, rd);
      chk("raw_read", rd, 32'h5);
      bus_xfer("rd_en_raw", 4'h4, 4'h0, 0, rd);
      chk("raw_wr_noeff", rd, 32'hFF00);

      // Reset during a pending read
      IRQ_IN = 16'h0008;
      bus_xfer("wr_mode_f0", 4'h8, 4'hF, 32'hF0, rd);
      bus_if.SEL = 1'b1; bus_if.VALID = 1'b1; bus_if.ADDR = 4'h4; bus_if.WSTRB = 4'h0;
      @(negedge CLK);
      RSTn = 1'b0;
      #1;
      chk("rst_mid_ready", 32'(bus_if.READY), 32'h0);
      tick();
      bus_if.SEL = 1'b0; bus_if.VALID = 1'b0;
      tick();
      RSTn = 1'b1;
      ready_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         if (bus_if.READY) ready_cnt++;
      end
      chk("rst_abort_noready", 32'(ready_cnt), 32'h0);
      tick();
      bus_xfer("rd_en_rst", 4'h4, 4'h0, 0, rd);   chk("rst2_enable", rd, 32'h0);
      bus_xfer("rd_mode_rst", 4'h8, 4'h0, 0, rd); chk("rst2_mode", rd, 32'h0);
      bus_xfer("rd_pend_rst", 4'h0, 4'h0, 0, rd); chk("rst2_pend_level", rd, 32'h8);
      chk("rst2_cpu_irq", CPU_IRQ, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
